// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default widths, write-back-op encodings and the
// field values a bubble leaves in a pipeline register.
package pipe_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 3;
  localparam int WBOP_W_DEF = 3;

  localparam logic [2:0] WBOP_ALU  = 3'b000;
  localparam logic [2:0] WBOP_LOAD = 3'b011;
  localparam logic [2:0] WBOP_PC   = 3'b100;

  localparam logic       BUBBLE_VALID = 1'b0;
  localparam logic       BUBBLE_WE    = 1'b0;
  localparam logic       BUBBLE_READS = 1'b0;
  localparam logic [2:0] BUBBLE_WBOP  = WBOP_ALU;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard: a load sitting in X writes a register that the
// instruction in D actually reads.
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int REG_W  = REG_W_DEF,
  parameter int WBOP_W = WBOP_W_DEF
) (
  input  logic              x_valid,
  input  logic              x_reg_write_en,
  input  logic [WBOP_W-1:0] x_write_back_op,
  input  logic [REG_W-1:0]  x_r_write_reg,
  input  logic              d_valid,
  input  logic              d_reads_reg1,
  input  logic [REG_W-1:0]  d_r_read_reg1,
  input  logic              d_reads_reg2,
  input  logic [REG_W-1:0]  d_r_read_reg2,
  output logic              load_use
);

  logic x_is_load;
  logic d_uses_dest;

  assign x_is_load   = x_valid & x_reg_write_en & (x_write_back_op == WBOP_W'(WBOP_LOAD));
  assign d_uses_dest = (d_reads_reg1 & (d_r_read_reg1 == x_r_write_reg)) |
                       (d_reads_reg2 & (d_r_read_reg2 == x_r_write_reg));
  assign load_use    = x_is_load & d_valid & d_uses_dest;

endmodule

// File: rtl/decode_execute_reg.sv
// Decode-to-execute pipeline register with load-use bubble insertion, flush
// squash, memory-stall freeze, write-back bypass and a saturating stall counter.
module decode_execute_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int WBOP_W = WBOP_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              D_valid,
  input  logic [DATA_W-1:0] D_pc,
  input  logic [REG_W-1:0]  D_rReadReg1,
  input  logic [REG_W-1:0]  D_rReadReg2,
  input  logic              D_readsReg1,
  input  logic              D_readsReg2,
  input  logic [DATA_W-1:0] D_rReadData1,
  input  logic [DATA_W-1:0] D_rReadData2,
  input  logic [DATA_W-1:0] D_imm,
  input  logic [REG_W-1:0]  D_rWriteReg,
  input  logic              D_regWriteEn,
  input  logic [WBOP_W-1:0] D_writeBackOp,
  input  logic [REG_W-1:0]  W_rWriteReg,
  input  logic              W_regWriteEn,
  input  logic [DATA_W-1:0] W_writeData,
  input  logic              flush,
  input  logic              memStall,
  output logic              X_valid,
  output logic [DATA_W-1:0] X_pc,
  output logic [REG_W-1:0]  X_rReadReg1,
  output logic [REG_W-1:0]  X_rReadReg2,
  output logic              X_readsReg1,
  output logic              X_readsReg2,
  output logic [DATA_W-1:0] X_rReadData1,
  output logic [DATA_W-1:0] X_rReadData2,
  output logic [DATA_W-1:0] X_imm,
  output logic [REG_W-1:0]  X_rWriteReg,
  output logic              X_regWriteEn,
  output logic [WBOP_W-1:0] X_writeBackOp,
  output logic              stallFD,
  output logic [CNT_W-1:0]  stallCount
);

  logic load_use;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // The register file reads before it writes, so a same-cycle write-back
  // must be picked up here or the value would be lost to the forwarding unit.
  function automatic logic [DATA_W-1:0] wb_bypass(
    input logic              reads,
    input logic [REG_W-1:0]  rid,
    input logic [DATA_W-1:0] rf_data,
    input logic              w_en,
    input logic [REG_W-1:0]  w_reg,
    input logic [DATA_W-1:0] w_data
  );
    return (w_en & reads & (w_reg == rid)) ? w_data : rf_data;
  endfunction

  load_use_detect #(
    .REG_W (REG_W),
    .WBOP_W(WBOP_W)
  ) u_load_use_detect (
    .x_valid        (X_valid),
    .x_reg_write_en (X_regWriteEn),
    .x_write_back_op(X_writeBackOp),
    .x_r_write_reg  (X_rWriteReg),
    .d_valid        (D_valid),
    .d_reads_reg1   (D_readsReg1),
    .d_r_read_reg1  (D_rReadReg1),
    .d_reads_reg2   (D_readsReg2),
    .d_r_read_reg2  (D_rReadReg2),
    .load_use       (load_use)
  );

  assign stallFD = load_use & ~flush;

  // D -> X stage boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      X_valid       <= 1'b0;
      X_pc          <= '0;
      X_rReadReg1   <= '0;
      X_rReadReg2   <= '0;
      X_readsReg1   <= 1'b0;
      X_readsReg2   <= 1'b0;
      X_rReadData1  <= '0;
      X_rReadData2  <= '0;
      X_imm         <= '0;
      X_rWriteReg   <= '0;
      X_regWriteEn  <= 1'b0;
      X_writeBackOp <= '0;
      stallCount    <= '0;
    end else if (!memStall) begin
      if (flush || load_use) begin
        X_valid       <= BUBBLE_VALID;
        X_pc          <= '0;
        X_rReadReg1   <= '0;
        X_rReadReg2   <= '0;
        X_readsReg1   <= BUBBLE_READS;
        X_readsReg2   <= BUBBLE_READS;
        X_rReadData1  <= '0;
        X_rReadData2  <= '0;
        X_imm         <= '0;
        X_rWriteReg   <= '0;
        X_regWriteEn  <= BUBBLE_WE;
        X_writeBackOp <= WBOP_W'(BUBBLE_WBOP);
        if (!flush) stallCount <= sat_inc(stallCount);
      end else begin
        X_valid       <= D_valid;
        X_pc          <= D_pc;
        X_rReadReg1   <= D_rReadReg1;
        X_rReadReg2   <= D_rReadReg2;
        X_readsReg1   <= D_readsReg1;
        X_readsReg2   <= D_readsReg2;
        X_rReadData1  <= wb_bypass(D_readsReg1, D_rReadReg1, D_rReadData1,
                                   W_regWriteEn, W_rWriteReg, W_writeData);
        X_rReadData2  <= wb_bypass(D_readsReg2, D_rReadReg2, D_rReadData2,
                                   W_regWriteEn, W_rWriteReg, W_writeData);
        X_imm         <= D_imm;
        X_rWriteReg   <= D_rWriteReg;
        X_regWriteEn  <= D_regWriteEn;
        X_writeBackOp <= D_writeBackOp;
      end
    end
  end

endmodule

// File: tb/tb_decode_execute_reg.sv
// Randomized and directed bench for decode_execute_reg against a behavioural
// model of the D->X register; a narrow-counter instance exercises saturation.
module tb_decode_execute_reg;
  import pipe_pkg::*;

  localparam int DW  = 16;
  localparam int RW  = 3;
  localparam int WW  = 3;
  localparam int CW  = 16;
  localparam int SCW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          D_valid, D_readsReg1, D_readsReg2, D_regWriteEn;
  logic [DW-1:0] D_pc, D_rReadData1, D_rReadData2, D_imm;
  logic [RW-1:0] D_rReadReg1, D_rReadReg2, D_rWriteReg;
  logic [WW-1:0] D_writeBackOp;
  logic [RW-1:0] W_rWriteReg;
  logic          W_regWriteEn;
  logic [DW-1:0] W_writeData;
  logic          flush, memStall;

  logic          X_valid, X_readsReg1, X_readsReg2, X_regWriteEn, stallFD;
  logic [DW-1:0] X_pc, X_rReadData1, X_rReadData2, X_imm;
  logic [RW-1:0] X_rReadReg1, X_rReadReg2, X_rWriteReg;
  logic [WW-1:0] X_writeBackOp;
  logic [CW-1:0] stallCount;

  logic          s_valid, s_readsReg1, s_readsReg2, s_regWriteEn, s_stallFD;
  logic [DW-1:0] s_pc, s_rReadData1, s_rReadData2, s_imm;
  logic [RW-1:0] s_rReadReg1, s_rReadReg2, s_rWriteReg;
  logic [WW-1:0] s_writeBackOp;
  logic [SCW-1:0] s_stallCount;

  decode_execute_reg #(.DATA_W(DW), .REG_W(RW), .WBOP_W(WW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .D_valid(D_valid), .D_pc(D_pc), .D_rReadReg1(D_rReadReg1), .D_rReadReg2(D_rReadReg2),
    .D_readsReg1(D_readsReg1), .D_readsReg2(D_readsReg2),
    .D_rReadData1(D_rReadData1), .D_rReadData2(D_rReadData2), .D_imm(D_imm),
    .D_rWriteReg(D_rWriteReg), .D_regWriteEn(D_regWriteEn), .D_writeBackOp(D_writeBackOp),
    .W_rWriteReg(W_rWriteReg), .W_regWriteEn(W_regWriteEn), .W_writeData(W_writeData),
    .flush(flush), .memStall(memStall),
    .X_valid(X_valid), .X_pc(X_pc), .X_rReadReg1(X_rReadReg1), .X_rReadReg2(X_rReadReg2),
    .X_readsReg1(X_readsReg1), .X_readsReg2(X_readsReg2),
    .X_rReadData1(X_rReadData1), .X_rReadData2(X_rReadData2), .X_imm(X_imm),
    .X_rWriteReg(X_rWriteReg), .X_regWriteEn(X_regWriteEn), .X_writeBackOp(X_writeBackOp),
    .stallFD(stallFD), .stallCount(stallCount)
  );

  decode_execute_reg #(.DATA_W(DW), .REG_W(RW), .WBOP_W(WW), .CNT_W(SCW)) dut_sat (
    .clk(clk), .rst(rst),
    .D_valid(D_valid), .D_pc(D_pc), .D_rReadReg1(D_rReadReg1), .D_rReadReg2(D_rReadReg2),
    .D_readsReg1(D_readsReg1), .D_readsReg2(D_readsReg2),
    .D_rReadData1(D_rReadData1), .D_rReadData2(D_rReadData2), .D_imm(D_imm),
    .D_rWriteReg(D_rWriteReg), .D_regWriteEn(D_regWriteEn), .D_writeBackOp(D_writeBackOp),
    .W_rWriteReg(W_rWriteReg), .W_regWriteEn(W_regWriteEn), .W_writeData(W_writeData),
    .flush(flush), .memStall(memStall),
    .X_valid(s_valid), .X_pc(s_pc), .X_rReadReg1(s_rReadReg1), .X_rReadReg2(s_rReadReg2),
    .X_readsReg1(s_readsReg1), .X_readsReg2(s_readsReg2),
    .X_rReadData1(s_rReadData1), .X_rReadData2(s_rReadData2), .X_imm(s_imm),
    .X_rWriteReg(s_rWriteReg), .X_regWriteEn(s_regWriteEn), .X_writeBackOp(s_writeBackOp),
    .stallFD(s_stallFD), .stallCount(s_stallCount)
  );

  // Reference model: the instruction currently held in execute, and the
  // number of load-use bubbles inserted so far (unbounded).
  logic          m_v, m_u1, m_u2, m_we;
  logic [DW-1:0] m_pc, m_d1, m_d2, m_imm;
  logic [RW-1:0] m_r1, m_r2, m_wr;
  logic [WW-1:0] m_wb;
  int unsigned   m_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic model_clear();
    {m_v, m_pc, m_r1, m_r2, m_u1, m_u2, m_d1, m_d2, m_imm, m_wr, m_we, m_wb} = '0;
  endtask

  function automatic logic model_hazard();
    logic x_load, d_needs;
    x_load  = m_v && m_we && (m_wb == WBOP_LOAD);
    d_needs = (D_readsReg1 && D_rReadReg1 == m_wr) || (D_readsReg2 && D_rReadReg2 == m_wr);
    return x_load && D_valid && d_needs;
  endfunction

  function automatic logic [79:0] model_vec();
    return {m_v, m_pc, m_r1, m_r2, m_u1, m_u2, m_d1, m_d2, m_imm, m_wr, m_we, m_wb};
  endfunction

  task automatic model_edge();
    logic hz;
    hz = model_hazard();
    if (memStall) return;
    if (flush || hz) begin
      model_clear();
      if (!flush) m_cnt++;
    end else begin
      m_v   = D_valid;      m_pc  = D_pc;
      m_r1  = D_rReadReg1;  m_r2  = D_rReadReg2;
      m_u1  = D_readsReg1;  m_u2  = D_readsReg2;
      m_d1  = (W_regWriteEn && D_readsReg1 && W_rWriteReg == D_rReadReg1) ? W_writeData : D_rReadData1;
      m_d2  = (W_regWriteEn && D_readsReg2 && W_rWriteReg == D_rReadReg2) ? W_writeData : D_rReadData2;
      m_imm = D_imm;        m_wr  = D_rWriteReg;
      m_we  = D_regWriteEn; m_wb  = D_writeBackOp;
    end
  endtask

  task automatic check_outs();
    check("x_fields", {X_valid, X_pc, X_rReadReg1, X_rReadReg2, X_readsReg1, X_readsReg2,
                       X_rReadData1, X_rReadData2, X_imm, X_rWriteReg, X_regWriteEn,
                       X_writeBackOp}, model_vec());
    check("stall_count", stallCount, (m_cnt > 65535) ? 65535 : m_cnt);
    check("sat_x_fields", {s_valid, s_pc, s_rReadReg1, s_rReadReg2, s_readsReg1, s_readsReg2,
                           s_rReadData1, s_rReadData2, s_imm, s_rWriteReg, s_regWriteEn,
                           s_writeBackOp}, model_vec());
    check("sat_stall_count", s_stallCount, (m_cnt > 7) ? 7 : m_cnt);
  endtask

  // Called at posedge+1 with inputs already applied.
  task automatic cycle();
    #1;
    check("stallFD", stallFD, model_hazard() && !flush);
    check("sat_stallFD", s_stallFD, model_hazard() && !flush);
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask

  task automatic set_idle();
    D_valid = 0; D_pc = '0; D_rReadReg1 = '0; D_rReadReg2 = '0;
    D_readsReg1 = 0; D_readsReg2 = 0; D_rReadData1 = '0; D_rReadData2 = '0;
    D_imm = '0; D_rWriteReg = '0; D_regWriteEn = 0; D_writeBackOp = '0;
    W_rWriteReg = '0; W_regWriteEn = 0; W_writeData = '0;
    flush = 0; memStall = 0;
  endtask

  task automatic set_d(input logic [DW-1:0] pc, input logic [RW-1:0] r1, input logic u1,
                       input logic [RW-1:0] r2, input logic u2, input logic [DW-1:0] d1,
                       input logic [DW-1:0] d2, input logic [RW-1:0] wr, input logic we,
                       input logic [WW-1:0] wb);
    D_valid = 1; D_pc = pc; D_rReadReg1 = r1; D_readsReg1 = u1;
    D_rReadReg2 = r2; D_readsReg2 = u2; D_rReadData1 = d1; D_rReadData2 = d2;
    D_imm = pc ^ 16'h00F0; D_rWriteReg = wr; D_regWriteEn = we; D_writeBackOp = wb;
  endtask

  task automatic load_r2();
    set_idle();
    set_d(16'h0010, 3'd0, 0, 3'd0, 0, 16'h0, 16'h0, 3'd2, 1, WBOP_LOAD);
    cycle();
  endtask

  initial begin
    m_cnt = 0;
    model_clear();
    set_idle();
    rst = 1;
    #12;
    check("reset_stallFD", stallFD, 0);
    check_outs();
    rst = 0;
    @(posedge clk); #1;

    // Load R2 followed by dependent ADD R3,R2,R1
    load_r2();
    check("ld_wbop", X_writeBackOp, WBOP_LOAD);
    set_d(16'h0012, 3'd2, 1, 3'd1, 1, 16'h1111, 16'h2222, 3'd3, 1, WBOP_ALU);
    #1 check("lu_stallFD", stallFD, 1);
    cycle();
    check("lu_bubble_valid", X_valid, 0);
    check("lu_count", stallCount, 1);
    #1 check("lu_release_stallFD", stallFD, 0);
    cycle();
    check("lu_add_valid", X_valid, 1);
    check("lu_add_dest", X_rWriteReg, 3);

    // Source register matches only through an unused field
    load_r2();
    set_d(16'h0014, 3'd4, 1, 3'd2, 0, 16'h4444, 16'h5555, 3'd5, 1, WBOP_ALU);
    #1 check("unused_stallFD", stallFD, 0);
    cycle();
    check("unused_valid", X_valid, 1);
    check("unused_count", stallCount, 1);

    // Load-use with flush and memStall, then flush alone
    load_r2();
    set_d(16'h0016, 3'd2, 1, 3'd1, 0, 16'h0, 16'h0, 3'd3, 1, WBOP_ALU);
    flush = 1; memStall = 1;
    #1 check("flush_stallFD", stallFD, 0);
    cycle();
    check("freeze_wbop", X_writeBackOp, WBOP_LOAD);
    check("freeze_valid", X_valid, 1);
    memStall = 0;
    cycle();
    check("flush_bubble", X_valid, 0);
    check("flush_count", stallCount, 1);

    // Write-back bypass on operand 2 only
    set_idle();
    set_d(16'h0020, 3'd6, 1, 3'd5, 1, 16'h5555, 16'h0000, 3'd7, 1, WBOP_ALU);
    W_regWriteEn = 1; W_rWriteReg = 3'd5; W_writeData = 16'h1234;
    cycle();
    check("bypass_op2", X_rReadData2, 16'h1234);
    check("bypass_op1", X_rReadData1, 16'h5555);

    // Asynchronous reset while a load-use stall is pending
    set_idle();
    set_d(16'h0030, 3'd0, 0, 3'd0, 0, 16'hBEEF, 16'h0, 3'd2, 1, WBOP_LOAD);
    cycle();
    check("pre_rst_d1", X_rReadData1, 16'hBEEF);
    set_d(16'h0032, 3'd2, 1, 3'd0, 0, 16'h0, 16'h0, 3'd1, 1, WBOP_ALU);
    rst = 1;
    #2;
    check("rst_valid", X_valid, 0);
    check("rst_d1", X_rReadData1, 0);
    check("rst_count", stallCount, 0);
    check("rst_stallFD", stallFD, 0);
    m_cnt = 0;
    model_clear();
    @(posedge clk); #1;
    check_outs();
    rst = 0;

    // Repeated load-use stalls to drive the narrow counter past its top
    for (int i = 0; i < 12; i++) begin
      load_r2();
      set_d(16'h0040, 3'd1, 0, 3'd2, 1, 16'h0, 16'h0, 3'd3, 1, WBOP_ALU);
      cycle();
    end
    check("sat_top", s_stallCount, 3'h7);
    check("wide_count", stallCount, 12);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int unsigned k;
      D_valid      = ($urandom_range(0, 7) != 0);
      D_pc         = 16'($urandom);
      D_rReadReg1  = 3'($urandom_range(0, 3));
      D_rReadReg2  = 3'($urandom_range(0, 3));
      D_readsReg1  = 1'($urandom);
      D_readsReg2  = 1'($urandom);
      D_rReadData1 = 16'($urandom);
      D_rReadData2 = 16'($urandom);
      D_imm        = 16'($urandom);
      D_rWriteReg  = 3'($urandom_range(0, 3));
      D_regWriteEn = ($urandom_range(0, 3) != 0);
      k = $urandom_range(0, 3);
      D_writeBackOp = (k == 0) ? WBOP_ALU : (k == 3) ? WBOP_PC : WBOP_LOAD;
      W_rWriteReg  = 3'($urandom_range(0, 3));
      W_regWriteEn = 1'($urandom);
      W_writeData  = 16'($urandom);
      flush        = ($urandom_range(0, 15) == 0);
      memStall     = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
